regfile_debug_port: RTL and testbench
=====================================

# regfile_debug_port

Debug/scan controller that acts as the initiator on the register file's read/write port interface. On command, it either dumps a contiguous range of registers onto a valid/ready byte stream or loads a range from an incoming byte stream. It sits between the debug link and the register file. While `busy` is high, the CPU-side port mux hands the register file ports to this block.

## Interface
- `NUM_REGS`, 8: number of registers; must equal 2**`ADDR_W`.
- `ADDR_W`, 3: register address width.
- `DATA_W`, 8: register data width.

- `clk` input 1: rising-edge clock.
- `rst` input 1: synchronous, active-low reset (0 = reset).
- `cmd_valid` input 1: command offered.
- `cmd_ready` output 1: block can accept a command (high in IDLE only).
- `cmd_op` input 1: 0 = dump, 1 = load.
- `cmd_addr` input ADDR_W: first register address.
- `cmd_count_m1` input ADDR_W: transfer count minus 1 (0..7, giving 1..8 bytes).
- `out_valid` output 1: dump byte valid.
- `out_ready` input 1: sink accepts the dump byte.
- `out_data` output DATA_W: dump byte.
- `out_last` output 1: high with the final dump byte.
- `in_valid` input 1: load byte valid.
- `in_ready` output 1: block accepts a load byte.
- `in_data` input DATA_W: load byte.
- `rf_read_addr` output ADDR_W: register file read address (drives `read_addr1`).
- `rf_read_data` input DATA_W: register file read data (`read_data1`), combinational from `rf_read_addr`.
- `rf_write_addr` output ADDR_W: register file write address.
- `rf_write_data` output DATA_W: register file write data.
- `rf_write_enable` output 1: register file write strobe; the register file writes on the next rising edge.
- `busy` output 1: high in any state other than IDLE.
- `done` output 1: one-cycle pulse when a command completes.

## Operation
- FSM states: IDLE, FETCH, SEND, LOAD, DONE.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`&`cmd_ready`: latch `cur_addr`=`cmd_addr` and `remaining`=`cmd_count_m1`.
  - Go to FETCH if `cmd_op`=0, or LOAD if `cmd_op`=1.
- FETCH:
  - `rf_read_addr`=`cur_addr`.
  - Register `out_data`<=`rf_read_data` and `out_last`<=(`remaining`==0).
  - Set `out_valid`<=1 and go to SEND.
- SEND:
  - Hold `out_valid`, `out_data` and `out_last` stable until `out_valid`&`out_ready`.
  - On that handshake: `out_valid`<=0.
  - If `remaining`==0, go to DONE.
  - Otherwise `cur_addr`++ and `remaining`--, then go to FETCH.
- LOAD:
  - `in_ready`=1.
  - `rf_write_enable`=`in_valid` (combinational), `rf_write_addr`=`cur_addr`, `rf_write_data`=`in_data`.
  - On each accepted byte: if `remaining`==0, go to DONE; otherwise `cur_addr`++ and `remaining`--.
  - Cycles with `in_valid`=0 produce no write and leave the address unchanged.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- Address arithmetic: `cur_addr` is ADDR_W wide and wraps modulo NUM_REGS (7 -> 0). Ranges crossing the top of the file are legal.
- `cmd_valid` while `busy` is ignored; no queuing.
- `rf_write_enable` is 0 in every state except LOAD. The block never reads and writes in the same cycle.
- `rf_read_addr` equals `cur_addr` in all states; only the FETCH sample is used.

## Timing
- Reset (`rst`=0 sampled at an edge):
  - State goes to IDLE; `cur_addr` and `remaining` go to 0.
  - `out_valid`, `out_data`, `out_last`, `done`, `busy` are 0 after the edge.
  - `cmd_ready` is 1 after the edge.
  - `in_ready` and `rf_write_enable` are gated to 0 combinationally whenever `rst`=0, so no write occurs on a reset edge.
- Reset mid-command: the transfer is abandoned, with no `done` pulse and no further writes. Registers already written keep their values.
- Dump latency:
  - Accept edge, then FETCH in the next cycle, then `out_valid` high in the cycle after that.
  - Each byte takes at least 2 cycles (FETCH and SEND).
  - The `done` pulse comes the cycle after the final handshake.
- Load latency:
  - `in_ready` is high starting the cycle after the accept edge; throughput is 1 byte/cycle.
  - The `done` pulse comes the cycle after the final accepted byte.
- A complete command is followed by 1 cycle of DONE, then 1 cycle of IDLE, before the next command can be accepted.

## Test plan
- Reset: hold `rst`=0 for 2 cycles with `cmd_valid`=1 and `in_valid`=1. Required: all outputs 0 and `rf_write_enable` never 1; `cmd_ready`=1 after release.
- Load: `cmd_addr`=2, `cmd_count_m1`=1, `in_data` 0xAA then 0xCC with `in_valid` held high. Required: writes R2=0xAA and R3=0xCC in consecutive cycles, then one `done` pulse.
- Dump with backpressure: R2=0xAA, R3=0xCC, R4=0x00; `cmd_addr`=2, `cmd_count_m1`=2; `out_ready` toggling 1,0. Required: stream 0xAA, 0xCC, 0x00, with data held during stalls and `out_last` only on 0x00.
- Wrap: load `cmd_addr`=6, `cmd_count_m1`=3 with data 0x11..0x44. Required: write addresses 6, 7, 0, 1 in that order; a following dump of the same range returns 0x11, 0x22, 0x33, 0x44.
- Load gaps and ignored command: `in_valid` pattern 1,0,0,1, plus `cmd_valid` pulsed while `busy`. Required: exactly 2 writes to consecutive addresses, and the extra command is not accepted.
- Reset mid-dump: assert `rst`=0 after the first byte handshake. Required: `out_valid`=0 and `busy`=0 after the edge, no `done` pulse, and a new command is accepted normally.

Source files
------------

// File: rtl/regfile_debug_port.sv
// regfile_debug_port: debug initiator that dumps or loads a register-file range over byte streams
module regfile_debug_port #(
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int DATA_W   = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_op,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [ADDR_W-1:0] i_cmd_count_m1,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_out_data,
  output logic              o_out_last,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [DATA_W-1:0] i_in_data,
  output logic [ADDR_W-1:0] o_rf_read_addr,
  input  logic [DATA_W-1:0] i_rf_read_data,
  output logic [ADDR_W-1:0] o_rf_write_addr,
  output logic [DATA_W-1:0] o_rf_write_data,
  output logic              o_rf_write_enable,
  output logic              o_busy,
  output logic              o_done
);
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_SEND, S_LOAD, S_DONE} state_t;
  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_cur_addr, r_remaining;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_valid, r_out_last;
  logic              w_last, w_step;
  assign w_last = r_remaining == '0;
  assign w_step = (r_state == S_SEND && i_out_ready) || (r_state == S_LOAD && i_in_valid);
  // next-state selection; a stepped transfer with nothing remaining finishes in DONE
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = i_cmd_valid ? (i_cmd_op ? S_LOAD : S_FETCH) : S_IDLE;
      S_FETCH: w_next = S_SEND;
      S_SEND:  w_next = i_out_ready ? (w_last ? S_DONE : S_FETCH) : S_SEND;
      S_LOAD:  w_next = (i_in_valid && w_last) ? S_DONE : S_LOAD;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end
  // state, address/count tracking and the registered dump output stage
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state     <= S_IDLE;
      r_cur_addr  <= '0;
      r_remaining <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && i_cmd_valid) begin
        r_cur_addr  <= i_cmd_addr;
        r_remaining <= i_cmd_count_m1;
      end else if (w_step && !w_last) begin
        r_cur_addr  <= r_cur_addr + ADDR_W'(1);
        r_remaining <= r_remaining - ADDR_W'(1);
      end
      if (r_state == S_FETCH) begin
        r_out_data  <= i_rf_read_data;
        r_out_last  <= w_last;
        r_out_valid <= 1'b1;
      end else if (r_state == S_SEND && i_out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end
  assign o_cmd_ready       = r_state == S_IDLE;
  assign o_busy            = r_state != S_IDLE;
  assign o_done            = r_state == S_DONE;
  assign o_out_valid       = r_out_valid;
  assign o_out_data        = r_out_data;
  assign o_out_last        = r_out_last;
  assign o_rf_read_addr    = r_cur_addr;
  assign o_rf_write_addr   = r_cur_addr;
  assign o_rf_write_data   = i_in_data;
  assign o_in_ready        = i_rst && r_state == S_LOAD;
  assign o_rf_write_enable = o_in_ready && i_in_valid;
endmodule

// File: tb/tb_regfile_debug_port.sv
// tb_regfile_debug_port: randomized and directed checks of the debug port against a register-image model
module tb_regfile_debug_port;
  logic       clk = 1'b0;
  logic       rst, cmd_valid, cmd_op, out_ready, in_valid;
  logic [2:0] cmd_addr, cmd_count_m1;
  logic [7:0] in_data;
  logic       cmd_ready, out_valid, out_last, in_ready, rf_we, busy, done;
  logic [7:0] out_data, rf_wd, rf_rd;
  logic [2:0] rf_ra, rf_wa;
  logic [7:0] rf [8] = '{default: 8'h00};
  logic [7:0] ref_mem [8] = '{default: 8'h00};
  logic [7:0] ld [8];
  int         n_tests = 0, n_fail = 0, wr_cnt = 0;

  regfile_debug_port #(.NUM_REGS(8), .ADDR_W(3), .DATA_W(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_op(cmd_op), .i_cmd_addr(cmd_addr), .i_cmd_count_m1(cmd_count_m1),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_data(out_data),
    .o_out_last(out_last), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_data(in_data), .o_rf_read_addr(rf_ra), .i_rf_read_data(rf_rd),
    .o_rf_write_addr(rf_wa), .o_rf_write_data(rf_wd), .o_rf_write_enable(rf_we),
    .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;

  // register file the block drives: combinational read, write on the edge after the strobe
  assign rf_rd = rf[rf_ra];
  always @(posedge clk) begin
    if (rf_we) begin
      rf[rf_wa] <= rf_wd;
      wr_cnt    <= wr_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic start_cmd(input bit op, input int a, input int m1);
    int k = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = 3'(a); cmd_count_m1 = 3'(m1);
    #1;
    while (!cmd_ready && k < 8) begin @(negedge clk); #1; k++; end
    chk("cmd_ready", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    chk("busy_after_accept", busy, 1);
  endtask

  task automatic load(input int a, input int m1, input int gap);
    int snap = wr_cnt;
    int g;
    start_cmd(1'b1, a, m1);
    for (int i = 0; i <= m1; i++) begin
      g = gap < 0 ? int'($urandom_range(0, 2)) : (i == 0 ? 0 : gap);
      repeat (g) begin
        in_valid = 1'b0; cmd_valid = 1'b1; cmd_op = 1'b0;
        #1;
        chk("gap_in_ready", in_ready, 1);
        chk("gap_no_write", rf_we, 0);
        chk("busy_cmd_ready", cmd_ready, 0);
        @(negedge clk);
      end
      cmd_valid = 1'b0; in_valid = 1'b1; in_data = ld[i];
      #1;
      chk("load_we", rf_we, 1);
      chk("load_addr", rf_wa, (a + i) % 8);
      chk("load_data", rf_wd, ld[i]);
      chk("load_no_done", done, 0);
      ref_mem[(a + i) % 8] = ld[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1;
    chk("load_done", done, 1);
    chk("load_write_count", wr_cnt - snap, m1 + 1);
    @(negedge clk); #1;
    chk("load_done_once", done, 0);
    chk("load_idle_ready", cmd_ready, 1);
  endtask

  task automatic dump(input int a, input int m1, input bit toggle);
    bit hs, rdy, tog = 1'b1;
    int k;
    start_cmd(1'b0, a, m1);
    for (int i = 0; i <= m1; i++) begin
      chk("fetch_gap_valid", out_valid, 0);
      @(negedge clk); #1;
      hs = 1'b0; k = 0;
      while (!hs && k < 20) begin
        chk("dump_valid", out_valid, 1);
        chk("dump_data", out_data, ref_mem[(a + i) % 8]);
        chk("dump_last", out_last, i == m1);
        chk("dump_no_done", done, 0);
        rdy = toggle ? tog : (k >= 8 ? 1'b1 : 1'($urandom));
        tog = ~tog;
        out_ready = rdy;
        @(negedge clk); #1;
        hs = rdy; k++;
      end
      if (!hs) chk("dump_handshake_timeout", 0, 1);
      out_ready = 1'b0;
      #1;
    end
    chk("dump_done", done, 1);
    chk("dump_valid_low", out_valid, 0);
    @(negedge clk); #1;
    chk("dump_done_once", done, 0);
    chk("dump_idle_ready", cmd_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int op, a, m1;
    rst = 1'b0; cmd_valid = 1'b1; cmd_op = 1'b1; cmd_addr = 3'd0; cmd_count_m1 = 3'd0;
    in_valid = 1'b1; in_data = 8'h5A; out_ready = 1'b0;
    #1;
    chk("rst_we_gated", rf_we, 0);
    repeat (2) begin
      @(negedge clk); #1;
      chk("rst_we", rf_we, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
    end
    chk("rst_no_writes", wr_cnt, 0);
    rst = 1'b1; cmd_valid = 1'b0; in_valid = 1'b0;
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    @(negedge clk); #1;
    chk("post_rst_idle", busy, 0);

    ld[0] = 8'hAA; ld[1] = 8'hCC;
    load(2, 1, 0);
    chk("r2", rf[2], 8'hAA);
    chk("r3", rf[3], 8'hCC);
    dump(2, 2, 1'b1);

    ld[0] = 8'h11; ld[1] = 8'h22; ld[2] = 8'h33; ld[3] = 8'h44;
    load(6, 3, 0);
    dump(6, 3, 1'b0);

    ld[0] = 8'h5E; ld[1] = 8'hE5;
    load(4, 1, 2);

    start_cmd(1'b0, 0, 3);
    chk("mid_fetch_valid", out_valid, 0);
    @(negedge clk); #1;
    chk("mid_first_data", out_data, ref_mem[0]);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0; rst = 1'b0;
    @(negedge clk); #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("mid_rst_no_done", done, 0);
    chk("mid_rst_ready", cmd_ready, 1);
    dump(5, 1, 1'b0);

    repeat (30) begin
      op = int'($urandom_range(0, 1));
      a  = int'($urandom_range(0, 7));
      m1 = int'($urandom_range(0, 7));
      if (op == 1) begin
        for (int i = 0; i < 8; i++) ld[i] = 8'($urandom);
        load(a, m1, -1);
      end else begin
        dump(a, m1, 1'($urandom));
      end
    end
    for (int i = 0; i < 8; i++) chk("final_image", rf[i], ref_mem[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
